// File: rtl/keypad_scan_ctrl.sv
// rtl/keypad_scan_ctrl.sv - 4x4 hex keypad column scanner with debounce; optional auto-repeat under KEYPAD_REPEAT_EN
module keypad_scan_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int REPEAT_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);

    // A debounce threshold of one means the first clean sample is already enough.
    localparam bit ACCEPT_ON_DETECT = (DEBOUNCE_CNT == 1);

    // Parameter sanity at elaboration time.
    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("keypad_scan_ctrl: SCAN_DIV must be >= 2");
    end
    if (DEBOUNCE_CNT < 1) begin : g_bad_debounce
        $error("keypad_scan_ctrl: DEBOUNCE_CNT must be >= 1");
    end
    if (REPEAT_TICKS < 1) begin : g_bad_repeat
        $error("keypad_scan_ctrl: REPEAT_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state;
    logic [3:0]      sync1;
    logic [3:0]      rs;
    logic [DW-1:0]   dwell;
    logic            tick;
    logic [1:0]      col_idx;
    logic [1:0]      col_next;
    logic [3:0]      cand;
    logic [CW-1:0]   dbc;
    logic [CW-1:0]   dbc_inc;
    logic [CW-1:0]   rel;
    logic [CW-1:0]   rel_inc;
    logic            single;
    logic [1:0]      row_idx;
    logic            cand_row_set;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    logic [RW-1:0]   rep;
    logic [RW-1:0]   rep_inc;
    assign rep_inc = (rep == RW'(REPEAT_TICKS)) ? rep : rep + RW'(1);
`endif

    // Two-flop synchroniser: row lines are asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'b0000;
            rs    <= 4'b0000;
        end else begin
            sync1 <= row_in;
            rs    <= sync1;
        end
    end

    // Column dwell counter; free-running in every state so ticks stay evenly spaced.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell <= '0;
        end else if (tick) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    assign tick = (dwell == DW'(SCAN_DIV - 1));

    // Classify the synchronised row sample: exactly one bit set, and which one.
    always_comb begin
        single  = 1'b0;
        row_idx = 2'd0;
        case (rs)
            4'b0001: begin single = 1'b1; row_idx = 2'd0; end
            4'b0010: begin single = 1'b1; row_idx = 2'd1; end
            4'b0100: begin single = 1'b1; row_idx = 2'd2; end
            4'b1000: begin single = 1'b1; row_idx = 2'd3; end
            default: begin single = 1'b0; row_idx = 2'd0; end
        endcase
    end

    // Only the candidate's own row line matters once a key is locked in.
    assign cand_row_set = rs[cand[1:0]];

    // Saturating increments so counters never wrap back to zero.
    assign dbc_inc  = (dbc == CW'(DEBOUNCE_CNT)) ? dbc : dbc + CW'(1);
    assign rel_inc  = (rel == CW'(DEBOUNCE_CNT)) ? rel : rel + CW'(1);
    assign col_next = col_idx + 2'd1;

    // Scan/debounce state machine with registered key outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            cand      <= 4'h0;
            dbc       <= '0;
            rel       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep       <= '0;
`endif
        end else begin
            key_valid <= 1'b0;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (single) begin
                            cand <= {col_idx, row_idx};
                            dbc  <= CW'(1);
                            if (ACCEPT_ON_DETECT) begin
                                key_code  <= {col_idx, row_idx};
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                dbc       <= '0;
                                state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                                rep       <= '0;
`endif
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end else begin
                            // Nothing pressed in this column, or a ghost/multi-key pattern.
                            col_idx <= col_next;
                        end
                    end

                    DEBOUNCE: begin
                        if (single && (row_idx == cand[1:0])) begin
                            dbc <= dbc_inc;
                            if (dbc_inc == CW'(DEBOUNCE_CNT)) begin
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                                dbc       <= '0;
                                state     <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                                rep       <= '0;
`endif
                            end
                        end else begin
                            // Bounce or changed pattern: give up and move on.
                            dbc     <= '0;
                            col_idx <= col_next;
                            state   <= SCAN;
                        end
                    end

                    PRESSED: begin
                        if (!cand_row_set) begin
`ifdef KEYPAD_REPEAT_EN
                            rep <= '0;
`endif
                            if (ACCEPT_ON_DETECT) begin
                                rel      <= '0;
                                key_held <= 1'b0;
                                col_idx  <= col_next;
                                state    <= SCAN;
                            end else begin
                                rel   <= CW'(1);
                                state <= RELEASE;
                            end
                        end else begin
`ifdef KEYPAD_REPEAT_EN
                            if (rep_inc == RW'(REPEAT_TICKS)) begin
                                key_valid <= 1'b1;
                                rep       <= '0;
                            end else begin
                                rep <= rep_inc;
                            end
`endif
                        end
                    end

                    RELEASE: begin
                        if (!cand_row_set) begin
                            rel <= rel_inc;
                            if (rel_inc == CW'(DEBOUNCE_CNT)) begin
                                rel      <= '0;
                                key_held <= 1'b0;
                                col_idx  <= col_next;
                                state    <= SCAN;
                            end
                        end else begin
                            // Release bounce: key is still down, no new strobe.
                            rel   <= '0;
                            state <= PRESSED;
`ifdef KEYPAD_REPEAT_EN
                            rep   <= '0;
`endif
                        end
                    end

                    default: begin
                        state <= SCAN;
                    end
                endcase
            end
        end
    end

    assign col_out = 4'b0001 << col_idx;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb/tb_keypad_scan_ctrl.sv - scoreboard bench for keypad_scan_ctrl
module tb_keypad_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    logic [15:0] key_mask;
    int          cyc;
    int          checks;
    int          failures;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    keypad_scan_ctrl #(
        .SCAN_DIV(4),
        .DEBOUNCE_CNT(3),
        .REPEAT_TICKS(5)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .row_in(row_in),
        .col_out(col_out),
        .key_code(key_code),
        .key_valid(key_valid),
        .key_held(key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix model: key (c,r) connects column c to row r.
    always_comb begin
        row_in = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col_out[c] && key_mask[c*4 + r]) row_in[r] = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic [3:0] code, input int at_cyc);
        exp_t e;
        e.code = code;
        e.cyc  = at_cyc;
        sb.push_back(e);
    endtask

    task automatic do_reset(input logic [15:0] m);
        @(negedge clk);
        rst_n    = 1'b0;
        key_mask = m;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Strobe monitor: every key_valid must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            check_eq("col_onehot", 32'($countones(col_out)), 32'd1);
            if (key_valid) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_valid", 32'(key_code), 32'hFFFF_FFFF);
                end else begin
                    mon_e = sb.pop_front();
                    check_eq("key_code", 32'(key_code), 32'(mon_e.code));
                    if (mon_e.cyc >= 0) check_eq("valid_cyc", 32'(cyc), 32'(mon_e.cyc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        key_mask = 16'h0000;

        // 1. reset values and free scanning
        do_reset(16'h0000);
        check_eq("rst_col", 32'(col_out), 32'h1);
        check_eq("rst_code", 32'(key_code), 32'h0);
        check_eq("rst_held", 32'(key_held), 32'h0);
        check_eq("rst_valid", 32'(key_valid), 32'h0);
        for (int k = 1; k <= 5; k++) begin
            wait_cyc(4*k - 1);
            check_eq("scan_dwell", 32'(col_out), 32'(1 << ((k-1) % 4)));
            wait_cyc(4*k);
            check_eq("scan_step", 32'(col_out), 32'(1 << (k % 4)));
        end
        check_eq("scan_code", 32'(key_code), 32'h0);

        // 2. clean press col 2 / row 1, held 20 ticks past accept
        do_reset(16'h0200);
        push(4'h9, 20);
`ifdef KEYPAD_REPEAT_EN
        push(4'h9, 40);
        push(4'h9, 60);
        push(4'h9, 80);
        push(4'h9, 100);
`endif
        wait_cyc(21);
        check_eq("press_held", 32'(key_held), 32'h1);
        check_eq("press_code", 32'(key_code), 32'h9);
        check_eq("press_col", 32'(col_out), 32'h4);
        wait_cyc(100);
        key_mask = 16'h0000;
        wait_cyc(108);
        check_eq("rel_pending", 32'(key_held), 32'h1);
        wait_cyc(112);
        check_eq("rel_done", 32'(key_held), 32'h0);
        check_eq("rel_resume_col", 32'(col_out), 32'h8);

        // 3. bounce on col 1 / row 3 for two ticks
        key_mask = 16'h0080;
        wait_cyc(128);
        check_eq("bounce_no_held", 32'(key_held), 32'h0);
        key_mask = 16'h0000;
        wait_cyc(131);
        check_eq("bounce_frozen", 32'(col_out), 32'h2);
        wait_cyc(132);
        check_eq("bounce_advance", 32'(col_out), 32'h4);
        check_eq("bounce_code", 32'(key_code), 32'h9);

        // 4. ghost: rows 0 and 2 together on col 0
        key_mask = 16'h0005;
        wait_cyc(143);
        check_eq("ghost_col0", 32'(col_out), 32'h1);
        wait_cyc(144);
        check_eq("ghost_skip", 32'(col_out), 32'h2);
        wait_cyc(148);
        check_eq("ghost_next", 32'(col_out), 32'h4);
        check_eq("ghost_held", 32'(key_held), 32'h0);

        // 5. release bounce, then async reset while pressed
        key_mask = 16'h0040;
        push(4'h6, 172);
        wait_cyc(176);
        key_mask = 16'h0000;
        wait_cyc(180);
        check_eq("rb_releasing", 32'(key_held), 32'h1);
        key_mask = 16'h0040;
        wait_cyc(184);
        check_eq("rb_back", 32'(key_held), 32'h1);
        wait_cyc(196);
        check_eq("rb_still", 32'(key_held), 32'h1);
        check_eq("rb_code", 32'(key_code), 32'h6);
        check_eq("rb_col", 32'(col_out), 32'h2);
        wait_cyc(198);
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_col", 32'(col_out), 32'h1);
        check_eq("arst_code", 32'(key_code), 32'h0);
        check_eq("arst_held", 32'(key_held), 32'h0);
        check_eq("arst_valid", 32'(key_valid), 32'h0);

        // 6. hold key F for 16 ticks after accept
        do_reset(16'h8000);
        push(4'hF, 24);
`ifdef KEYPAD_REPEAT_EN
        push(4'hF, 44);
        push(4'hF, 64);
        push(4'hF, 84);
`endif
        wait_cyc(88);
        key_mask = 16'h0000;
        wait_cyc(100);
        check_eq("hold_rel", 32'(key_held), 32'h0);
        check_eq("hold_wrap_col", 32'(col_out), 32'h1);

        // sweep every key in order
        for (int k = 0; k < 16; k++) begin
            key_mask = 16'(1 << k);
            push(4'(k), -1);
            n = 0;
            while (!key_held && n < 200) begin
                @(negedge clk);
                n++;
            end
            check_eq("sweep_held", 32'(key_held), 32'h1);
            key_mask = 16'h0000;
            n = 0;
            while (key_held && n < 200) begin
                @(negedge clk);
                n++;
            end
            check_eq("sweep_rel", 32'(key_held), 32'h0);
        end

        repeat (8) @(negedge clk);
        check_eq("sb_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
